// File: rtl/ext_mem_pkg.sv
// Shared width helpers for the external memory arbiter and its round-robin arbiters.
package ext_mem_pkg;

    // Address width for a memory of the given depth, never narrower than one bit.
    function automatic int addr_width(input int height);
        return (height > 32'sd1) ? $clog2(height) : 32'sd1;
    endfunction

    // Width of a requester index for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/ext_mem_arbiter_rr.sv
// Round-robin arbiter: searches from the pointer upward with wrap, grants the
// first requester when allowed, and moves the pointer past the winner.
module rr_arbiter
    import ext_mem_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = id_width(N)
) (
    input  logic           clk,
    input  logic           arst_n_in,
    input  logic [N-1:0]   i_req,
    input  logic           i_grant_allow,
    input  logic           i_update,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_found
);

    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_idx;
    logic           w_found;
    int             w_cand;

    // Find the first requester at or after the pointer, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = 0;
        for (int i = 0; i < N; i++) begin
            w_cand = (int'(r_ptr) + i) % N;
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = IDW'(w_cand);
            end else begin
                w_found = w_found;
                w_idx   = w_idx;
            end
        end
    end

    // Drive the one-hot grant only when the caller allows it this cycle.
    always_comb begin
        if (w_found && i_grant_allow) begin
            o_gnt = N'(1'b1) << w_idx;
        end else begin
            o_gnt = '0;
        end
        o_idx   = w_idx;
        o_found = w_found;
    end

    // Pointer moves to one past the winner on an accepted grant, else holds.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            r_ptr <= '0;
        end else if (i_update && w_found) begin
            r_ptr <= IDW'((int'(w_idx) + 1) % N);
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Arbitrates multiple readers and writers onto a pseudo-2-port external memory.
// Memory-side signals are registered; read returns are tagged back to the
// requesting reader through a {valid, id} pipeline that matches memory latency.
module ext_mem_arbiter
    import ext_mem_pkg::*;
#(
    parameter int EXT_MEM_HEIGHT = 1 << 20,
    parameter int EXT_MEM_WIDTH  = 32,
    parameter int NB_READERS     = 3,
    parameter int NB_WRITERS     = 2,
    parameter int RD_LATENCY     = 1,
    parameter int CNT_WIDTH      = 32,
    parameter int ADDR_W         = addr_width(EXT_MEM_HEIGHT)
) (
    input  logic                             clk,
    input  logic                             arst_n_in,
    input  logic                             enable,
    input  logic [NB_READERS-1:0]            rd_req,
    input  logic [NB_READERS*ADDR_W-1:0]     rd_addr,
    output logic [NB_READERS-1:0]            rd_gnt,
    output logic [EXT_MEM_WIDTH-1:0]         rd_data,
    output logic [NB_READERS-1:0]            rd_valid,
    input  logic [NB_WRITERS-1:0]            wr_req,
    input  logic [NB_WRITERS*ADDR_W-1:0]     wr_addr,
    input  logic [NB_WRITERS*EXT_MEM_WIDTH-1:0] wr_data,
    output logic [NB_WRITERS-1:0]            wr_gnt,
    output logic [ADDR_W-1:0]                ext_mem_read_addr,
    output logic                             ext_mem_read_en,
    input  logic [EXT_MEM_WIDTH-1:0]         ext_mem_qout,
    output logic [ADDR_W-1:0]                ext_mem_write_addr,
    output logic [EXT_MEM_WIDTH-1:0]         ext_mem_din,
    output logic                             ext_mem_write_en,
    input  logic                             clear_counters,
    output logic [CNT_WIDTH-1:0]             rd_word_count,
    output logic [CNT_WIDTH-1:0]             wr_word_count,
    output logic                             busy
);

    localparam int RIDW  = id_width(NB_READERS);
    localparam int WIDW  = id_width(NB_WRITERS);
    localparam int DEPTH = 1 + RD_LATENCY;

    logic [RIDW-1:0]          w_rd_idx;
    logic [WIDW-1:0]          w_wr_idx;
    logic                     w_rd_found;
    logic                     w_wr_found;
    logic [ADDR_W-1:0]        w_rd_win_addr;
    logic [ADDR_W-1:0]        w_wr_win_addr;
    logic [EXT_MEM_WIDTH-1:0] w_wr_win_data;
    logic                     w_hazard;
    logic                     w_rd_allow;
    logic                     w_wr_allow;
    logic                     w_rd_issue;
    logic                     w_wr_issue;

    logic [ADDR_W-1:0]           r_read_addr;
    logic                        r_read_en;
    logic [ADDR_W-1:0]           r_write_addr;
    logic [EXT_MEM_WIDTH-1:0]    r_din;
    logic                        r_write_en;
    logic [DEPTH-1:0]            r_tag_vld;
    logic [DEPTH-1:0][RIDW-1:0]  r_tag_id;
    logic [CNT_WIDTH-1:0]        r_rd_cnt;
    logic [CNT_WIDTH-1:0]        r_wr_cnt;

    rr_arbiter #(.N(NB_READERS)) u_rd_arb (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .i_req         (rd_req),
        .i_grant_allow (w_rd_allow),
        .i_update      (w_rd_allow),
        .o_gnt         (rd_gnt),
        .o_idx         (w_rd_idx),
        .o_found       (w_rd_found)
    );

    rr_arbiter #(.N(NB_WRITERS)) u_wr_arb (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .i_req         (wr_req),
        .i_grant_allow (w_wr_allow),
        .i_update      (w_wr_allow),
        .o_gnt         (wr_gnt),
        .o_idx         (w_wr_idx),
        .o_found       (w_wr_found)
    );

    // Select the address of the current read winner.
    always_comb begin
        w_rd_win_addr = '0;
        for (int i = 0; i < NB_READERS; i++) begin
            if (w_rd_idx == RIDW'(i)) begin
                w_rd_win_addr = rd_addr[i*ADDR_W +: ADDR_W];
            end else begin
                w_rd_win_addr = w_rd_win_addr;
            end
        end
    end

    // Select the address and data of the current write winner.
    always_comb begin
        w_wr_win_addr = '0;
        w_wr_win_data = '0;
        for (int i = 0; i < NB_WRITERS; i++) begin
            if (w_wr_idx == WIDW'(i)) begin
                w_wr_win_addr = wr_addr[i*ADDR_W +: ADDR_W];
                w_wr_win_data = wr_data[i*EXT_MEM_WIDTH +: EXT_MEM_WIDTH];
            end else begin
                w_wr_win_addr = w_wr_win_addr;
                w_wr_win_data = w_wr_win_data;
            end
        end
    end

    // A read colliding with this cycle's write is held back one cycle so it
    // sees the freshly written word; the write always goes ahead.
    always_comb begin
        w_hazard   = w_rd_found && w_wr_found && (w_rd_win_addr == w_wr_win_addr);
        w_wr_allow = arst_n_in && enable;
        w_rd_allow = arst_n_in && enable && !w_hazard;
        w_rd_issue = w_rd_found && w_rd_allow;
        w_wr_issue = w_wr_found && w_wr_allow;
    end

    // Memory-side registers: enables follow the grant, address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            r_read_en    <= 1'b0;
            r_read_addr  <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_din        <= '0;
        end else begin
            r_read_en  <= w_rd_issue;
            r_write_en <= w_wr_issue;
            if (w_rd_issue) begin
                r_read_addr <= w_rd_win_addr;
            end else begin
                r_read_addr <= r_read_addr;
            end
            if (w_wr_issue) begin
                r_write_addr <= w_wr_win_addr;
                r_din        <= w_wr_win_data;
            end else begin
                r_write_addr <= r_write_addr;
                r_din        <= r_din;
            end
        end
    end

    // Tag pipeline carrying {valid, reader id} alongside the memory read latency.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_rd_issue;
            r_tag_id[0]  <= w_rd_idx;
            for (int s = 1; s < DEPTH; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    // Saturating bandwidth counters; a clear wins over a same-cycle grant.
    always_ff @(posedge clk) begin
        if (!arst_n_in || clear_counters) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_issue && (r_rd_cnt != {CNT_WIDTH{1'b1}})) begin
                r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1'b1);
            end else begin
                r_rd_cnt <= r_rd_cnt;
            end
            if (w_wr_issue && (r_wr_cnt != {CNT_WIDTH{1'b1}})) begin
                r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1'b1);
            end else begin
                r_wr_cnt <= r_wr_cnt;
            end
        end
    end

    // Decode the returning tag; nothing is reported while reset is held.
    always_comb begin
        if (arst_n_in && r_tag_vld[DEPTH-1]) begin
            rd_valid = NB_READERS'(1'b1) << r_tag_id[DEPTH-1];
        end else begin
            rd_valid = '0;
        end
    end

    assign rd_data            = ext_mem_qout;
    assign ext_mem_read_addr  = r_read_addr;
    assign ext_mem_read_en    = r_read_en;
    assign ext_mem_write_addr = r_write_addr;
    assign ext_mem_din        = r_din;
    assign ext_mem_write_en   = r_write_en;
    assign rd_word_count      = r_rd_cnt;
    assign wr_word_count      = r_wr_cnt;
    assign busy               = (|r_tag_vld) | r_write_en;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Bench for ext_mem_arbiter: directed scenarios plus randomized traffic, all
// checked each cycle against a transaction-level model (round-robin picks,
// shadow memory updated in grant order, queue of expected read returns).
module tb_ext_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          enable;
    logic [2:0]    rd_req;
    logic [3*AW-1:0] rd_addr;
    logic [2:0]    rd_gnt;
    logic [DW-1:0] rd_data;
    logic [2:0]    rd_valid;
    logic [1:0]    wr_req;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [1:0]    wr_gnt;
    logic [AW-1:0] ext_mem_read_addr;
    logic          ext_mem_read_en;
    logic [DW-1:0] ext_mem_qout;
    logic [AW-1:0] ext_mem_write_addr;
    logic [DW-1:0] ext_mem_din;
    logic          ext_mem_write_en;
    logic          clear_counters;
    logic [CW-1:0] rd_word_count;
    logic [CW-1:0] wr_word_count;
    logic          busy;

    ext_mem_arbiter #(
        .EXT_MEM_HEIGHT (256),
        .EXT_MEM_WIDTH  (DW),
        .NB_READERS     (3),
        .NB_WRITERS     (2),
        .RD_LATENCY     (1),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk                (clk),
        .arst_n_in          (arst_n_in),
        .enable             (enable),
        .rd_req             (rd_req),
        .rd_addr            (rd_addr),
        .rd_gnt             (rd_gnt),
        .rd_data            (rd_data),
        .rd_valid           (rd_valid),
        .wr_req             (wr_req),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .wr_gnt             (wr_gnt),
        .ext_mem_read_addr  (ext_mem_read_addr),
        .ext_mem_read_en    (ext_mem_read_en),
        .ext_mem_qout       (ext_mem_qout),
        .ext_mem_write_addr (ext_mem_write_addr),
        .ext_mem_din        (ext_mem_din),
        .ext_mem_write_en   (ext_mem_write_en),
        .clear_counters     (clear_counters),
        .rd_word_count      (rd_word_count),
        .wr_word_count      (wr_word_count),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Power-up content of the external memory (address 0x10 holds 0xCAFE0001).
    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 16) return 32'hCAFE0001;
        return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0203);
    endfunction

    // External memory: one-cycle registered read port, separate write port.
    logic [DW-1:0] mem [256];
    bit            mem_wr [256];
    always @(posedge clk) begin
        if (ext_mem_read_en)
            ext_mem_qout <= mem_wr[ext_mem_read_addr] ? mem[ext_mem_read_addr]
                                                      : init_word(int'(ext_mem_read_addr));
        if (ext_mem_write_en) begin
            mem[ext_mem_write_addr]    <= ext_mem_din;
            mem_wr[ext_mem_write_addr] <= 1'b1;
        end
    end

    // ---------------- reference model state ----------------
    typedef struct { int due; int id; logic [DW-1:0] data; } ret_t;
    ret_t          m_q[$];
    logic [DW-1:0] sh [256];
    bit            sh_wr [256];
    int            m_rptr = 0, m_wptr = 0, m_rcnt = 0, m_wcnt = 0, cyc = 0;
    logic          m_ren = 1'b0, m_wen = 1'b0;
    logic [AW-1:0] m_raddr = '0, m_waddr = '0;
    logic [DW-1:0] m_din = '0;

    logic [2:0]    obs_rg, obs_rv;
    logic [1:0]    obs_wg;
    logic [DW-1:0] obs_rdata;
    logic          obs_ren, obs_wen, obs_busy;
    logic [AW-1:0] obs_raddr;
    logic [CW-1:0] obs_rcnt, obs_wcnt;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int ptr, input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            c = (ptr + k) % n;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
        return sh_wr[a] ? sh[a] : init_word(int'(a));
    endfunction

    function automatic int oh2i(input logic [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock cycle: sample mid-cycle, compare against the model, advance the model.
    task automatic step();
        int rw, ww;
        bit hz, busy_e;
        logic [2:0] e_rg, e_rv;
        logic [1:0] e_wg;
        logic [DW-1:0] e_rd;
        logic [AW-1:0] ra;
        #3;
        rw = rr_pick({1'b0, rd_req}, m_rptr, 3);
        ww = rr_pick({2'b00, wr_req}, m_wptr, 2);
        e_rg = 3'b000;
        e_wg = 2'b00;
        ra = (rw >= 0) ? rd_addr[rw*AW +: AW] : '0;
        if (arst_n_in && enable) begin
            if (ww >= 0) e_wg = 2'(2'b01 << ww);
            hz = (rw >= 0) && (ww >= 0) && (ra == wr_addr[ww*AW +: AW]);
            if (rw >= 0 && !hz) e_rg = 3'(3'b001 << rw);
        end
        busy_e = (m_q.size() != 0) || m_wen;
        e_rv = 3'b000;
        e_rd = '0;
        if (m_q.size() != 0 && m_q[0].due == cyc) begin
            if (arst_n_in) begin
                e_rv = 3'(3'b001 << m_q[0].id);
                e_rd = m_q[0].data;
            end
            void'(m_q.pop_front());
        end

        obs_rg = rd_gnt; obs_wg = wr_gnt; obs_rv = rd_valid; obs_rdata = rd_data;
        obs_ren = ext_mem_read_en; obs_raddr = ext_mem_read_addr; obs_wen = ext_mem_write_en;
        obs_rcnt = rd_word_count; obs_wcnt = wr_word_count; obs_busy = busy;

        check("rd_gnt", 64'(rd_gnt), 64'(e_rg));
        check("wr_gnt", 64'(wr_gnt), 64'(e_wg));
        check("rd_valid", 64'(rd_valid), 64'(e_rv));
        if (e_rv != 3'b000) check("rd_data", 64'(rd_data), 64'(e_rd));
        check("read_en", 64'(ext_mem_read_en), 64'(m_ren));
        check("read_addr", 64'(ext_mem_read_addr), 64'(m_raddr));
        check("write_en", 64'(ext_mem_write_en), 64'(m_wen));
        check("write_addr", 64'(ext_mem_write_addr), 64'(m_waddr));
        check("din", 64'(ext_mem_din), 64'(m_din));
        check("rd_count", 64'(rd_word_count), 64'(m_rcnt));
        check("wr_count", 64'(wr_word_count), 64'(m_wcnt));
        check("busy", 64'(busy), 64'(busy_e));

        if (!arst_n_in) begin
            m_q.delete();
            m_rptr = 0; m_wptr = 0; m_rcnt = 0; m_wcnt = 0;
            m_ren = 1'b0; m_wen = 1'b0; m_raddr = '0; m_waddr = '0; m_din = '0;
        end else begin
            if (e_rg != 3'b000) begin
                m_q.push_back('{cyc + 2, rw, sh_rd(ra)});
                m_ren = 1'b1; m_raddr = ra;
                m_rptr = (rw + 1) % 3;
            end else begin
                m_ren = 1'b0;
            end
            if (e_wg != 2'b00) begin
                m_waddr = wr_addr[ww*AW +: AW];
                m_din   = wr_data[ww*DW +: DW];
                sh[m_waddr] = m_din; sh_wr[m_waddr] = 1'b1;
                m_wen = 1'b1;
                m_wptr = (ww + 1) % 2;
            end else begin
                m_wen = 1'b0;
            end
            if (clear_counters) begin
                m_rcnt = 0; m_wcnt = 0;
            end else begin
                if (e_rg != 3'b000 && m_rcnt < 15) m_rcnt++;
                if (e_wg != 2'b00 && m_wcnt < 15) m_wcnt++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        arst_n_in = 1'b0; rd_req = '0; wr_req = '0; clear_counters = 1'b0; enable = 1'b1;
        step();
        arst_n_in = 1'b1;
    endtask

    initial begin
        int gq[$];
        int vq[$];
        int npulse;
        bit sawv;
        logic [1:0] en_exp [6];
        bit en_seq [6];

        arst_n_in = 1'b0; enable = 1'b1; clear_counters = 1'b0;
        rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: requests present but nothing granted, everything zero.
        rd_req = 3'b111; wr_req = 2'b11;
        step();
        check("rst_rd_gnt", 64'(obs_rg), 64'(0));
        check("rst_wr_gnt", 64'(obs_wg), 64'(0));
        check("rst_busy", 64'(obs_busy), 64'(0));
        check("rst_rcnt", 64'(obs_rcnt), 64'(0));

        // Single reader from a preloaded address.
        do_reset();
        rd_req = 3'b010; rd_addr[1*AW +: AW] = 8'h10;
        step();
        check("t1_gnt", 64'(obs_rg), 64'(3'b010));
        rd_req = 3'b000;
        step();
        check("t1_ren", 64'(obs_ren), 64'(1));
        check("t1_raddr", 64'(obs_raddr), 64'(8'h10));
        step();
        check("t1_valid", 64'(obs_rv), 64'(3'b010));
        check("t1_data", 64'(obs_rdata), 64'(32'hCAFE0001));
        check("t1_cnt", 64'(obs_rcnt), 64'(1));

        // Three readers continuously: strict rotation, returns in the same order.
        do_reset();
        rd_addr = {8'h03, 8'h02, 8'h01}; rd_req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_rg != 3'b000) gq.push_back(oh2i(obs_rg));
            if (obs_rv != 3'b000) vq.push_back(oh2i(obs_rv));
        end
        rd_req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step();
            if (obs_rv != 3'b000) vq.push_back(oh2i(obs_rv));
        end
        check("t2_ngnt", 64'(gq.size()), 64'(6));
        check("t2_nvalid", 64'(vq.size()), 64'(6));
        for (int i = 0; i < 6 && i < gq.size() && i < vq.size(); i++) begin
            check("t2_gnt_order", 64'(gq[i]), 64'(i % 3));
            check("t2_ret_order", 64'(vq[i]), 64'(i % 3));
        end
        check("t2_cnt", 64'(obs_rcnt), 64'(6));

        // Read/write to the same address in the same cycle.
        do_reset();
        wr_req = 2'b01; wr_addr[0 +: AW] = 8'h20; wr_data[0 +: DW] = 32'h0000_1234;
        rd_req = 3'b001; rd_addr[0 +: AW] = 8'h20;
        step();
        check("t3_wgnt", 64'(obs_wg), 64'(2'b01));
        check("t3_rheld", 64'(obs_rg), 64'(0));
        wr_req = 2'b00;
        step();
        check("t3_rgnt", 64'(obs_rg), 64'(3'b001));
        rd_req = 3'b000;
        step();
        step();
        check("t3_valid", 64'(obs_rv), 64'(3'b001));
        check("t3_data", 64'(obs_rdata), 64'(32'h0000_1234));

        // Two writers with enable low for two cycles in between.
        do_reset();
        wr_req = 2'b11; wr_addr = {8'h31, 8'h30}; wr_data = {32'hBBBB_0001, 32'hAAAA_0000};
        en_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        en_exp = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            enable = en_seq[i];
            step();
            check("t4_wgnt", 64'(obs_wg), 64'(en_exp[i]));
            if (obs_wg != 2'b00) npulse++;
        end
        enable = 1'b1; wr_req = 2'b00;
        step();
        check("t4_cnt", 64'(obs_wcnt), 64'(npulse));

        // Reset right after a read grant: the read never returns.
        do_reset();
        rd_req = 3'b001; rd_addr[0 +: AW] = 8'h40;
        step();
        rd_req = 3'b000; arst_n_in = 1'b0;
        step();
        arst_n_in = 1'b1;
        sawv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (obs_rv != 3'b000) sawv = 1'b1;
        end
        check("t5_novalid", 64'(sawv), 64'(0));
        check("t5_rcnt", 64'(obs_rcnt), 64'(0));
        check("t5_busy", 64'(obs_busy), 64'(0));
        check("t5_ren", 64'(obs_ren), 64'(0));
        check("t5_wen", 64'(obs_wen), 64'(0));
        rd_req = 3'b111; rd_addr = {8'h43, 8'h42, 8'h41};
        step();
        check("t5_first", 64'(obs_rg), 64'(3'b001));
        rd_req = 3'b000;
        step();

        // Counter saturation at 15, then clear with a simultaneous grant.
        do_reset();
        rd_req = 3'b001; rd_addr[0 +: AW] = 8'h50;
        for (int i = 0; i < 20; i++) step();
        check("t6_sat", 64'(obs_rcnt), 64'(15));
        clear_counters = 1'b1;
        step();
        clear_counters = 1'b0; rd_req = 3'b000;
        step();
        check("t6_clear", 64'(obs_rcnt), 64'(0));
        step();
        step();

        // Randomized traffic: requesters hold until granted, may withdraw.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!rd_req[i]) begin
                    if ($urandom_range(0, 99) < 50) begin
                        rd_req[i] = 1'b1;
                        rd_addr[i*AW +: AW] = 8'($urandom_range(0, 7));
                    end
                end else if ($urandom_range(0, 99) < 4) begin
                    rd_req[i] = 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!wr_req[i]) begin
                    if ($urandom_range(0, 99) < 40) begin
                        wr_req[i] = 1'b1;
                        wr_addr[i*AW +: AW] = 8'($urandom_range(0, 7));
                        wr_data[i*DW +: DW] = $urandom;
                    end
                end else if ($urandom_range(0, 99) < 4) begin
                    wr_req[i] = 1'b0;
                end
            end
            enable = ($urandom_range(0, 9) != 0);
            clear_counters = ($urandom_range(0, 49) == 0);
            arst_n_in = ($urandom_range(0, 149) != 0);
            step();
            rd_req = rd_req & ~obs_rg;
            wr_req = wr_req & ~obs_wg;
        end
        arst_n_in = 1'b1; rd_req = '0; wr_req = '0; clear_counters = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
